button_conditioner: RTL and testbench



---
 rtl/button_conditioner_if.sv | 27 ++
 rtl/button_conditioner.sv | 159 +++++++++++++++
 tb/tb_button_conditioner.sv | 108 ++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Event bundle between the raw push-buttons and the control unit.
// The release pulse is carried on 'rel' because 'release' is a reserved word.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] KEY;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] step;

    modport master (
        output KEY,
        input  level,
        input  press,
        input  rel,
        input  step
    );

    modport slave (
        input  KEY,
        output level,
        output press,
        output rel,
        output step
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button conditioner: polarity fix, 2-FF synchronizer, debounce counter,
// then press/release edge pulses and an auto-repeating step pulse.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    button_conditioner_if.slave  btn
);

    localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW       = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DLY_V     = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] RATE_V    = HW'(REPEAT_RATE);
    localparam bit            REPEAT_EN = (REPEAT_DELAY > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    function automatic logic [DW-1:0] deb_inc(input logic [DW-1:0] v);
        return (v == {DW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [HW-1:0] hold_inc(input logic [HW-1:0] v);
        return (v == {HW{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [N_BTN-1:0] raw_n;
    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] press_v;
    logic [N_BTN-1:0] rel_v;
    logic [N_BTN-1:0] step_v;

    // 1 = pressed from here on, whatever the board wiring
    assign raw_n = ACTIVE_LOW ? ~btn.KEY : btn.KEY;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic            meta_p0;
        logic            sync_p1;
        logic            lvl_p2;
        logic            press_p2;
        logic            rel_p2;
        logic            step_p2;
        logic [DW-1:0]   dcnt_p2;
        logic [DW-1:0]   dcnt_nxt;
        logic [HW-1:0]   hcnt_p2;
        logic [HW-1:0]   hcnt_nxt;
        logic [HW-1:0]   hinc;
        rep_state_t      st_p2;
        rep_state_t      st_nxt;
        logic            flip;
        logic            rise;
        logic            fall;
        logic            rpt;

        // stage p0/p1: synchronizer, resets to the released value
        always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
                meta_p0 <= 1'b0;
                sync_p1 <= 1'b0;
            end else begin
                meta_p0 <= raw_n[i];
                sync_p1 <= meta_p0;
            end
        end

        // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing edge
        always_comb begin
            flip     = (sync_p1 != lvl_p2) && (dcnt_p2 == DEB_LAST);
            rise     = flip && sync_p1;
            fall     = flip && !sync_p1;
            dcnt_nxt = '0;
            if ((sync_p1 != lvl_p2) && !flip) begin
                dcnt_nxt = deb_inc(dcnt_p2);
            end
        end

        always_comb begin
            st_nxt   = st_p2;
            hcnt_nxt = hcnt_p2;
            rpt      = 1'b0;
            hinc     = hold_inc(hcnt_p2);
            if (rise) begin
                st_nxt   = REPEAT_EN ? ST_DELAY : ST_IDLE;
                hcnt_nxt = '0;
            end else if (fall || !lvl_p2) begin
                // a falling level kills any repeat that would land on this edge
                st_nxt   = ST_IDLE;
                hcnt_nxt = '0;
            end else begin
                case (st_p2)
                    ST_DELAY: begin
                        if (hinc == DLY_V) begin
                            rpt      = 1'b1;
                            hcnt_nxt = '0;
                            st_nxt   = ST_REPEAT;
                        end else begin
                            hcnt_nxt = hinc;
                        end
                    end
                    ST_REPEAT: begin
                        if (hinc == RATE_V) begin
                            rpt      = 1'b1;
                            hcnt_nxt = '0;
                        end else begin
                            hcnt_nxt = hinc;
                        end
                    end
                    default: begin
                        st_nxt   = ST_IDLE;
                        hcnt_nxt = '0;
                    end
                endcase
            end
        end

        // stage p2: debounced level, counters, repeat state and registered pulses
        always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
                lvl_p2   <= 1'b0;
                dcnt_p2  <= '0;
                hcnt_p2  <= '0;
                st_p2    <= ST_IDLE;
                press_p2 <= 1'b0;
                rel_p2   <= 1'b0;
                step_p2  <= 1'b0;
            end else begin
                lvl_p2   <= flip ? sync_p1 : lvl_p2;
                dcnt_p2  <= dcnt_nxt;
                hcnt_p2  <= hcnt_nxt;
                st_p2    <= st_nxt;
                press_p2 <= rise;
                rel_p2   <= fall;
                step_p2  <= rise || rpt;
            end
        end

        assign level_v[i] = lvl_p2;
        assign press_v[i] = press_p2;
        assign rel_v[i]   = rel_p2;
        assign step_v[i]  = step_p2;
    end

    assign btn.level = level_v;
    assign btn.press = press_v;
    assign btn.rel   = rel_v;
    assign btn.step  = step_v;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat settings.
module tb_button_conditioner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    button_conditioner_if #(.N_BTN(N)) bus ();

    button_conditioner #(
        .N_BTN           (N),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .btn      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h ({level,press,rel,step})", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.level, bus.press, bus.rel, bus.step};
    endfunction

    // Press 'chans' before edge 0, release before edge rel_edge; observe after each edge k.
    task automatic run_press(input string tag, input logic [N-1:0] chans,
                             input int rel_edge, input int ncyc);
        logic [N-1:0] el, ep, er, es;
        int p, fe;
        p  = D + 1;
        fe = rel_edge + D + 1;
        for (int k = 0; k < ncyc; k++) begin
            bus.KEY = (k < rel_edge) ? ~chans : {N{1'b1}};
            @(posedge clk);
            @(negedge clk);
            el = (k >= p && k < fe) ? chans : '0;
            ep = (k == p) ? chans : '0;
            er = (k == fe) ? chans : '0;
            es = ((k == p) || (k >= p + RD && k < fe && ((k - p - RD) % RR) == 0)) ? chans : '0;
            chk($sformatf("%s k=%0d", tag, k), outs(), {el, ep, er, es});
        end
    endtask

    initial begin
        logic [N-1:0] el, ep, es;
        bus.KEY = {N{1'b1}};
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), 16'h0000);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", outs(), 16'h0000);

        run_press("clean", 4'b0001, 20, 30);

        for (int k = 0; k < 15; k++) begin
            bus.KEY = (k < 3 || (k >= 5 && k < 8)) ? 4'b1101 : 4'b1111;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bounce k=%0d", k), outs(), 16'h0000);
        end

        run_press("repeat", 4'b0100, 31, 40);
        run_press("rel_in_repeat", 4'b0100, 14, 24);
        run_press("simultaneous", 4'b1111, 8, 16);

        // KEY[2] into its repeat phase, KEY[3] mid-debounce, then reset
        for (int k = 0; k <= 18; k++) begin
            bus.KEY = (k >= 16) ? 4'b0011 : 4'b1011;
            @(posedge clk);
            @(negedge clk);
            el = (k >= D + 1) ? 4'b0100 : 4'b0000;
            ep = (k == D + 1) ? 4'b0100 : 4'b0000;
            es = (k == 5 || k == 15 || k == 18) ? 4'b0100 : 4'b0000;
            chk($sformatf("pre_reset k=%0d", k), outs(), {el, ep, 4'b0000, es});
        end
        #2 rst = 1'b1;
        #1 chk("reset_async", outs(), 16'h0000);
        @(posedge clk);
        @(negedge clk);
        chk("reset_hold", outs(), 16'h0000);
        bus.KEY = 4'b1011;
        rst     = 1'b0;
        run_press("reset_resume", 4'b0100, 8, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
